// File: rtl/cdc_fifo_pkg.sv
// Gray/binary pointer helpers shared by the dual-clock FIFO halves.
// Functions work on 32 bits; callers size the result to their pointer width.
package cdc_fifo_pkg;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = '0;
      for (int i = 0; i < 32; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/cluster_event_fifo_dst_if.sv
// Registered valid/ready event stream towards the cluster event unit.
// Signal names follow the producer (FIFO) side of the link.
interface cluster_event_fifo_dst_if #(
   parameter int LOG_DEPTH  = 3,
   parameter int EVNT_WIDTH = 8
);
   logic                  evt_valid_o;
   logic [EVNT_WIDTH-1:0] evt_data_o;
   logic                  evt_ready_i;
   logic [LOG_DEPTH:0]    evt_fill_o;

   modport master (
      output evt_valid_o,
      output evt_data_o,
      output evt_fill_o,
      input  evt_ready_i
   );

   modport slave (
      input  evt_valid_o,
      input  evt_data_o,
      input  evt_fill_o,
      output evt_ready_i
   );
endinterface

// File: rtl/cdc_ptr_sync.sv
// Plain flop chain bringing a Gray pointer into the local clock domain.
// Shared with the AXI async channel halves.
module cdc_ptr_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] ptr_i,
   output logic [WIDTH-1:0] ptr_o
);

   logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] sync_d [STAGES];

   always_comb begin
      sync_d[0] = ptr_i;
      for (int i = 1; i < STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
      end
   end

   assign ptr_o = sync_q[STAGES-1];

endmodule

// File: rtl/cluster_event_fifo_dst.sv
// Cluster-side read half of the SoC-to-cluster event CDC FIFO.
// Pops entries from the source-owned storage into a registered output stage.
module cluster_event_fifo_dst
   import cdc_fifo_pkg::*;
#(
   parameter int LOG_DEPTH   = 3,
   parameter int EVNT_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [LOG_DEPTH:0]    async_cluster_events_wptr_i,
   input  logic [EVNT_WIDTH-1:0] async_cluster_events_data_i [2**LOG_DEPTH],
   output logic [LOG_DEPTH:0]    async_cluster_events_rptr_o,
   cluster_event_fifo_dst_if.master evt
);

   localparam int PW = LOG_DEPTH + 1;

   logic [PW-1:0]         wptr_sync_gray;
   logic [PW-1:0]         rptr_bin_q, rptr_bin_d;
   logic [PW-1:0]         rptr_gray_q, rptr_gray_d;
   logic                  evt_valid_q, evt_valid_d;
   logic [EVNT_WIDTH-1:0] evt_data_q, evt_data_d;
   logic                  empty;
   logic                  load;

   cdc_ptr_sync #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_wptr_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .ptr_i (async_cluster_events_wptr_i),
      .ptr_o (wptr_sync_gray)
   );

   assign empty = (wptr_sync_gray == rptr_gray_q);
   assign load  = !empty && (!evt_valid_q || evt.evt_ready_i);

   always_comb begin
      rptr_bin_d  = rptr_bin_q;
      rptr_gray_d = rptr_gray_q;
      evt_valid_d = evt_valid_q;
      evt_data_d  = evt_data_q;
      if (load) begin
         evt_data_d  = async_cluster_events_data_i[rptr_bin_q[LOG_DEPTH-1:0]];
         evt_valid_d = 1'b1;
         rptr_bin_d  = rptr_bin_q + PW'(1);
         rptr_gray_d = PW'(bin2gray(32'(rptr_bin_d)));
      end else if (evt_valid_q && evt.evt_ready_i) begin
         evt_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rptr_bin_q  <= '0;
         rptr_gray_q <= '0;
         evt_valid_q <= 1'b0;
         evt_data_q  <= '0;
      end else begin
         rptr_bin_q  <= rptr_bin_d;
         rptr_gray_q <= rptr_gray_d;
         evt_valid_q <= evt_valid_d;
         evt_data_q  <= evt_data_d;
      end
   end

   // Fill counts what is still in storage; the output register is excluded.
   assign evt.evt_fill_o = PW'(gray2bin(32'(wptr_sync_gray))) - rptr_bin_q;
   assign evt.evt_valid_o = evt_valid_q;
   assign evt.evt_data_o  = evt_data_q;
   assign async_cluster_events_rptr_o = rptr_gray_q;

endmodule

// File: tb/tb_cluster_event_fifo_dst.sv
// Scoreboard bench: a behavioural SoC-side writer feeds the FIFO,
// a negedge monitor checks every delivered event against the queue.
module tb_cluster_event_fifo_dst;

   localparam int LD = 3;
   localparam int W  = 8;
   localparam int PW = LD + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [PW-1:0] wptr = '0;
   logic [PW-1:0] rptr;
   logic [W-1:0]  mem [2**LD];

   always #5 clk = ~clk;

   cluster_event_fifo_dst_if #(.LOG_DEPTH(LD), .EVNT_WIDTH(W)) evt ();

   cluster_event_fifo_dst #(
      .LOG_DEPTH   (LD),
      .EVNT_WIDTH  (W),
      .SYNC_STAGES (2)
   ) dut (
      .clk_i                       (clk),
      .rst_i                       (rst),
      .async_cluster_events_wptr_i (wptr),
      .async_cluster_events_data_i (mem),
      .async_cluster_events_rptr_o (rptr),
      .evt                         (evt.master)
   );

   int tests = 0;
   int fails = 0;
   int pops  = 0;
   int wbin  = 0;
   logic [W-1:0] exp_q [$];

   function automatic logic [PW-1:0] b2g(input int b);
      logic [PW-1:0] v;
      v = PW'(b);
      return v ^ (v >> 1);
   endfunction

   function automatic int g2b(input logic [PW-1:0] g);
      int r;
      r = 0;
      for (int i = PW - 1; i >= 0; i--) begin
         r = r | ((((r >> (i + 1)) & 1) ^ int'(g[i])) << i);
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s got=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   always @(negedge clk) begin
      if (!rst && evt.evt_valid_o && evt.evt_ready_i) begin
         pops++;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL pop_unexpected got=%0h required=none",
                     evt.evt_data_o);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (evt.evt_data_o !== e) begin
               fails++;
               $display("FAIL pop_data got=%0h required=%0h",
                        evt.evt_data_o, e);
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      evt.evt_ready_i = 1'b0;
      exp_q.delete();
      wbin = 0;
      wptr = '0;
      repeat (2) step();
      rst = 1'b0;
      step();
   endtask

   task automatic write_evt(input logic [W-1:0] v);
      int n;
      n = 0;
      while ((((wbin - g2b(rptr)) & 15) >= 8) && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) check("write_full_timeout", 1, 0);
      mem[wbin % 8] = v;
      wbin = (wbin + 1) % 16;
      wptr = b2g(wbin);
      exp_q.push_back(v);
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!evt.evt_valid_o && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) check(name, 0, 1);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      evt.evt_ready_i = 1'b1;
      while ((exp_q.size() != 0 || evt.evt_valid_o) && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) check(name, 0, 1);
   endtask

   initial begin
      int p0;
      logic [W-1:0] v0;
      for (int i = 0; i < 2**LD; i++) mem[i] = '0;
      evt.evt_ready_i = 1'b0;
      do_reset();

      for (int i = 0; i < 20; i++) begin
         check("idle_valid", 32'(evt.evt_valid_o), 0);
         check("idle_rptr", 32'(rptr), 0);
         check("idle_fill", 32'(evt.evt_fill_o), 0);
         step();
      end

      evt.evt_ready_i = 1'b1;
      write_evt(8'hA5);
      step();
      check("lat_e1_valid", 32'(evt.evt_valid_o), 0);
      step();
      check("lat_e2_valid", 32'(evt.evt_valid_o), 0);
      step();
      check("lat_e3_valid", 32'(evt.evt_valid_o), 1);
      check("lat_e3_data", 32'(evt.evt_data_o), 32'hA5);
      check("lat_e3_rptr", 32'(rptr), 32'b0001);
      step();
      check("lat_drop_valid", 32'(evt.evt_valid_o), 0);
      check("lat_queue_empty", 32'(exp_q.size()), 0);

      do_reset();
      for (int i = 0; i < 8; i++) write_evt(8'($urandom));
      v0 = exp_q[0];
      wait_valid("full_valid_timeout");
      check("full_fill", 32'(evt.evt_fill_o), 7);
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_valid", 32'(evt.evt_valid_o), 1);
         check("hold_data", 32'(evt.evt_data_o), 32'(v0));
         check("hold_rptr", 32'(rptr), 32'(b2g(1)));
      end
      p0 = pops;
      evt.evt_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("burst_valid", 32'(evt.evt_valid_o), 1);
         step();
      end
      check("burst_end_valid", 32'(evt.evt_valid_o), 0);
      check("burst_pops", 32'(pops - p0), 8);
      check("burst_rptr", 32'(rptr), 32'b1100);

      do_reset();
      p0 = pops;
      for (int i = 0; i < 20; i++) begin
         write_evt(8'(i));
         repeat ($urandom_range(0, 2)) begin
            evt.evt_ready_i = ($urandom_range(0, 3) != 0);
            step();
         end
         evt.evt_ready_i = ($urandom_range(0, 3) != 0);
         step();
         if (g2b(rptr) >= 8 && pops - p0 < 8 && evt.evt_valid_o)
            check("wrap_msb_lap1", 32'(rptr[PW-1]), 1);
      end
      drain("wrap_drain_timeout");
      check("wrap_pops", 32'(pops - p0), 20);
      check("wrap_rptr", 32'(rptr), 32'(b2g(20 % 16)));
      check("wrap_fill", 32'(evt.evt_fill_o), 0);

      do_reset();
      p0 = pops;
      for (int i = 0; i < 3; i++) begin
         mem[i] = 8'($urandom);
         exp_q.push_back(mem[i]);
      end
      wbin = 3;
      wptr = b2g(3);
      step();
      check("jump_fill_e1", 32'(evt.evt_fill_o), 0);
      step();
      check("jump_fill_e2", 32'(evt.evt_fill_o), 3);
      check("jump_valid_e2", 32'(evt.evt_valid_o), 0);
      step();
      check("jump_valid_e3", 32'(evt.evt_valid_o), 1);
      check("jump_fill_e3", 32'(evt.evt_fill_o), 2);
      drain("jump_drain_timeout");
      check("jump_pops", 32'(pops - p0), 3);
      check("jump_fill_end", 32'(evt.evt_fill_o), 0);

      do_reset();
      for (int i = 0; i < 5; i++) write_evt(8'($urandom));
      wait_valid("rst_valid_timeout");
      step();
      check("rst_pre_valid", 32'(evt.evt_valid_o), 1);
      check("rst_pre_fill", 32'(evt.evt_fill_o), 4);
      #1;
      rst = 1'b1;
      #1;
      check("rst_async_valid", 32'(evt.evt_valid_o), 0);
      check("rst_async_data", 32'(evt.evt_data_o), 0);
      check("rst_async_fill", 32'(evt.evt_fill_o), 0);
      check("rst_async_rptr", 32'(rptr), 0);
      exp_q.delete();
      wbin = 0;
      wptr = '0;
      step();
      step();
      rst = 1'b0;
      evt.evt_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("rst_post_valid", 32'(evt.evt_valid_o), 0);
      end
      check("rst_post_fill", 32'(evt.evt_fill_o), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
